muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV32IM pipeline's EX stage; it executes the eight M-extension operations that the control unit encodes on ALUOP. The unit raises BUSY_WAIT while an operation runs, and the control unit and pipeline registers stall on that signal. It is the consumer end of the ALUOP/BUSY_WAIT interface. Plain ALU operations never reach it.

---
 rtl/rv32im_pkg.sv | 52 +++++
 rtl/muldiv_iter_core.sv | 33 +++
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM execute-stage definitions: ALUOP codes, the M-extension group
// prefix, the muldiv FSM states, and helpers that decode operand signedness.
package rv32im_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // Base ALU operations (never routed to the muldiv unit)
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b10000;
  localparam logic [4:0] ALU_AND    = 5'b10001;

  // M-extension operations: group prefix 2'b01 in ALUOP[4:3]
  localparam logic [4:0] ALU_MUL    = 5'b01000;
  localparam logic [4:0] ALU_MULH   = 5'b01001;
  localparam logic [4:0] ALU_MULHU  = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_DIV    = 5'b01100;
  localparam logic [4:0] ALU_DIVU   = 5'b01101;
  localparam logic [4:0] ALU_REM    = 5'b01110;
  localparam logic [4:0] ALU_REMU   = 5'b01111;

  localparam logic [1:0] MULDIV_GRP = 2'b01;

  localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;

  // Latched request: low ALUOP bits select the operation, neg_res flips the final value
  typedef struct packed {
    logic [2:0] op;
    logic       neg_res;
  } md_req_t;

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b011) || (op == 3'b100) || (op == 3'b110);
  endfunction

  // rs2 is signed for MULH, DIV, REM
  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add (multiply) or restoring shift-subtract (divide) step.
// Latency: purely combinational, the owning FSM registers the result.
// Backpressure: none; the caller decides when the step is committed.
module muldiv_iter_core
  import rv32im_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_sub;

  // Multiply: {hi,lo} with multiplier in lo; add multiplicand to hi on lo[0], shift right.
  // Divide: {rem,quo} with dividend in quo; shift left, subtract divisor when it fits.
  always_comb begin
    add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    rem_sh  = acc_in[2*XLEN-1:XLEN-1];
    fits    = (rem_sh >= {1'b0, operand});
    rem_sub = rem_sh[XLEN-1:0] - operand;
    if (is_div) begin
      if (fits) acc_out = {rem_sub, acc_in[XLEN-2:0], 1'b1};
      else      acc_out = {acc_in[2*XLEN-2:0], 1'b0};
    end else begin
      acc_out = {add_sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with sign fix-up and divide special cases.
// Latency: 33 cycles accept-to-result; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: BUSY_WAIT stalls the pipeline from the accept cycle until the result cycle.
module muldiv_unit
  import rv32im_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALUOP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID,
  output logic            BUSY_WAIT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  md_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  md_req_t           req;

  logic [2:0]        op_in;
  logic              accept, neg1, neg2, div_zero, div_ovf, fast;
  logic [XLEN-1:0]   mag1, mag2, fast_res;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   div_sel, calc_res;

  assign op_in  = ALUOP[2:0];
  assign accept = (state == IDLE) && START && (ALUOP[4:3] == MULDIV_GRP);

  // Incoming request: operand magnitudes and the divide cases that bypass iteration
  always_comb begin
    neg1     = rs1_signed(op_in) && DATA1[XLEN-1];
    neg2     = rs2_signed(op_in) && DATA2[XLEN-1];
    mag1     = neg1 ? -DATA1 : DATA1;
    mag2     = neg2 ? -DATA2 : DATA2;
    div_zero = op_in[2] && (DATA2 == '0);
    div_ovf  = op_in[2] && !op_in[0] && (DATA1 == SIGN_MIN) && (DATA2 == ALL_ONES);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op_in[1] ? DATA1 : ALL_ONES;
    else          fast_res = op_in[1] ? '0 : SIGN_MIN;
  end

  muldiv_iter_core u_core (
    .is_div  (req.op[2]),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_nxt)
  );

  // Final value from the last iteration: full-width negate for products, per-half for divide
  always_comb begin
    mul_fix = req.neg_res ? -acc_nxt : acc_nxt;
    div_sel = req.op[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (req.op[2])               calc_res = req.neg_res ? -div_sel : div_sel;
    else if (req.op[1:0] == '0)  calc_res = mul_fix[XLEN-1:0];
    else                         calc_res = mul_fix[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; BUSY_WAIT covers the accept cycle so EX holds
  always_comb begin
    state_nxt    = state;
    BUSY_WAIT    = 1'b0;
    RESULT_VALID = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          BUSY_WAIT = 1'b1;
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: begin
        BUSY_WAIT = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        RESULT_VALID = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request on accept, iterate in CALC, load RESULT on the edge into DONE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      req    <= '0;
      RESULT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt         <= '0;
            req.op      <= op_in;
            req.neg_res <= (op_in[2] && op_in[1]) ? neg1 : (neg1 ^ neg2);
            acc         <= op_in[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            opnd        <= op_in[2] ? mag2 : mag1;
            if (fast) RESULT <= fast_res;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= acc_nxt;
          if (cnt == CNT_LAST) RESULT <= calc_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomised checks of muldiv_unit results, stall length
// and result-pulse timing, with a queue of expected results filled at issue time.
module tb_muldiv_unit;
  import rv32im_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [4:0]  ALUOP;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [31:0] RESULT;
  logic        RESULT_VALID;
  logic        BUSY_WAIT;

  int checks   = 0;
  int failures = 0;

  logic [31:0] scoreboard[$];

  muldiv_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .ALUOP        (ALUOP),
    .DATA1        (DATA1),
    .DATA2        (DATA2),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .BUSY_WAIT    (BUSY_WAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference behaviour of the eight M operations, special cases included
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      s1, s2, u1, u2;
    logic [63:0] pv;
    logic        ovf;
    s1  = $signed(a);
    s2  = $signed(b);
    u1  = {32'h0, a};
    u2  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pv  = '0;
    case (op[2:0])
      3'd0: begin pv = u1 * u2; return pv[31:0];  end
      3'd1: begin pv = s1 * s2; return pv[63:32]; end
      3'd2: begin pv = u1 * u2; return pv[63:32]; end
      3'd3: begin pv = s1 * u2; return pv[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        pv = s1 / s2; return pv[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pv = u1 / u2; return pv[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        pv = s1 % s2; return pv[31:0];
      end
      default: begin
        if (b == 0) return a;
        pv = u1 % u2; return pv[31:0];
      end
    endcase
  endfunction

  // Drive one request, push its expected result, then watch until RESULT_VALID (bounded).
  // busy_cyc counts sampled cycles with BUSY_WAIT high, accept cycle included.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, output int busy_cyc, output int done_cyc,
                       output logic [31:0] got);
    scoreboard.push_back(exp);
    @(negedge CLK);
    START = 1'b1; ALUOP = op; DATA1 = a; DATA2 = b;
    #1;
    busy_cyc = BUSY_WAIT ? 1 : 0;
    done_cyc = -1;
    got      = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    START = 1'b0; ALUOP = 5'b0; DATA1 = '0; DATA2 = '0;
    for (int i = 1; i <= 60 && done_cyc < 0; i++) begin
      @(negedge CLK);
      if (BUSY_WAIT === 1'b1) busy_cyc++;
      if (RESULT_VALID === 1'b1) begin
        done_cyc = i;
        got      = RESULT;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b0; ALUOP = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if (RESULT !== 32'h0) begin
      failures++; $display("FAIL reset_result got=%h exp=%h", RESULT, 32'h0);
    end
    checks++;
    if (RESULT_VALID !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", RESULT_VALID);
    end
    checks++;
    if (BUSY_WAIT !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", BUSY_WAIT);
    end
    RESET = 1'b1;
  endtask

  task automatic test_mul();
    int busy, done; logic [31:0] got, exp;
    issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, busy, done, got);
    exp = scoreboard.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL mul_result got=%h exp=%h", got, exp); end
    checks++;
    if (busy !== 33) begin failures++; $display("FAIL mul_busy got=%0d exp=33", busy); end
    checks++;
    if (done !== 33) begin failures++; $display("FAIL mul_done_cycle got=%0d exp=33", done); end
    @(negedge CLK);
    checks++;
    if (RESULT_VALID !== 1'b0 || RESULT !== exp) begin
      failures++;
      $display("FAIL mul_pulse_hold valid=%b result=%h exp valid=0 result=%h",
               RESULT_VALID, RESULT, exp);
    end
  endtask

  task automatic test_mulh();
    logic [4:0]  ops[3]  = '{ALU_MULH, ALU_MULHU, ALU_MULHSU};
    logic [31:0] exps[3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int busy, done; logic [31:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], 32'hFFFF_FFFF, 32'hFFFF_FFFF, exps[k], busy, done, got);
      exp = scoreboard.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL mulh_result op=%b got=%h exp=%h", ops[k], got, exp);
      end
      checks++;
      if (done !== 33) begin
        failures++; $display("FAIL mulh_done_cycle op=%b got=%0d exp=33", ops[k], done);
      end
    end
  endtask

  task automatic test_div_rem();
    logic [4:0]  ops[4] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int busy, done; logic [31:0] got, exp;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], as[k], bs[k], ex[k], busy, done, got);
      exp = scoreboard.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL divrem_result op=%b got=%h exp=%h", ops[k], got, exp);
      end
      checks++;
      if (busy !== 33) begin
        failures++; $display("FAIL divrem_busy op=%b got=%0d exp=33", ops[k], busy);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [4:0]  ops[2] = '{ALU_DIVU, ALU_REM};
    logic [31:0] ex[2]  = '{32'hFFFF_FFFF, 32'd5};
    int busy, done; logic [31:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      issue(ops[k], 32'd5, 32'd0, ex[k], busy, done, got);
      exp = scoreboard.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL divzero_result op=%b got=%h exp=%h", ops[k], got, exp);
      end
      checks++;
      if (busy !== 1) begin
        failures++; $display("FAIL divzero_busy op=%b got=%0d exp=1", ops[k], busy);
      end
      checks++;
      if (done !== 1) begin
        failures++; $display("FAIL divzero_done_cycle op=%b got=%0d exp=1", ops[k], done);
      end
    end
  endtask

  task automatic test_overflow();
    logic [4:0]  ops[2] = '{ALU_DIV, ALU_REM};
    logic [31:0] ex[2]  = '{32'h8000_0000, 32'h0};
    int busy, done; logic [31:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      issue(ops[k], 32'h8000_0000, 32'hFFFF_FFFF, ex[k], busy, done, got);
      exp = scoreboard.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL ovf_result op=%b got=%h exp=%h", ops[k], got, exp);
      end
      checks++;
      if (busy !== 1) begin
        failures++; $display("FAIL ovf_busy op=%b got=%0d exp=1", ops[k], busy);
      end
      checks++;
      if (done !== 1) begin
        failures++; $display("FAIL ovf_done_cycle op=%b got=%0d exp=1", ops[k], done);
      end
    end
  endtask

  // Each request is driven in the IDLE cycle straight after the previous DONE
  task automatic test_back_to_back();
    int busy, done, lat; logic [31:0] got, exp, a, b; logic [4:0] op; logic fast;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        op = ALU_MULHU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      end else begin
        op = {2'b01, 3'($urandom_range(0, 7))}; a = $urandom; b = $urandom;
      end
      fast = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat  = fast ? 1 : 33;
      issue(op, a, b, ref_model(op, a, b), busy, done, got);
      exp = scoreboard.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_result op=%b a=%h b=%h got=%h exp=%h", op, a, b, got, exp);
      end
      checks++;
      if (busy !== lat) begin
        failures++; $display("FAIL b2b_busy op=%b got=%0d exp=%0d", op, busy, lat);
      end
      checks++;
      if (done !== lat) begin
        failures++; $display("FAIL b2b_done_cycle op=%b got=%0d exp=%0d", op, done, lat);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int busy, done; logic [31:0] got, exp;
    @(negedge CLK);
    START = 1'b1; ALUOP = ALU_DIV; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0; ALUOP = '0; DATA1 = '0; DATA2 = '0;
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY_WAIT !== 1'b1) begin
      failures++; $display("FAIL midop_busy_before_reset got=%b exp=1", BUSY_WAIT);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (BUSY_WAIT !== 1'b0) begin
      failures++; $display("FAIL midop_reset_busy got=%b exp=0", BUSY_WAIT);
    end
    checks++;
    if (RESULT_VALID !== 1'b0) begin
      failures++; $display("FAIL midop_reset_valid got=%b exp=0", RESULT_VALID);
    end
    checks++;
    if (RESULT !== 32'h0) begin
      failures++; $display("FAIL midop_reset_result got=%h exp=%h", RESULT, 32'h0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    START = 1'b1; ALUOP = ALU_ADD; DATA1 = 32'd9; DATA2 = 32'd9;
    #1;
    checks++;
    if (BUSY_WAIT !== 1'b0) begin
      failures++; $display("FAIL nonmd_busy_same_cycle got=%b exp=0", BUSY_WAIT);
    end
    @(negedge CLK);
    checks++;
    if (BUSY_WAIT !== 1'b0 || RESULT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL nonmd_ignored busy=%b valid=%b exp busy=0 valid=0", BUSY_WAIT, RESULT_VALID);
    end
    START = 1'b0; ALUOP = '0; DATA1 = '0; DATA2 = '0;
    issue(ALU_MUL, 32'd3, 32'd4, 32'd12, busy, done, got);
    exp = scoreboard.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL post_reset_mul got=%h exp=%h", got, exp); end
    checks++;
    if (busy !== 33) begin failures++; $display("FAIL post_reset_busy got=%0d exp=33", busy); end
    checks++;
    if (done !== 33) begin failures++; $display("FAIL post_reset_done got=%0d exp=33", done); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div_rem();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
